// File: rtl/mux_rr_scheduler_pkg.sv
// Shared constants, types and helpers for the round-robin mux scheduler.
// Imported by the interface, the datapath mux and the scheduler top.
package mux_rr_scheduler_pkg;

    localparam int NUM_REQ   = 4;
    localparam int SEL_W     = 2;
    localparam int CNT_W     = 4;
    localparam int MAX_BURST = 15;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
        return NUM_REQ'(1) << s;
    endfunction

endpackage

// File: rtl/mux_rr_scheduler_if.sv
// Requester/consumer bundle around the scheduler.
// The slave modport is the scheduler's view; master is the surrounding system's view.
interface mux_rr_scheduler_if
    import mux_rr_scheduler_pkg::*;
#(
    parameter int DATA_W = 8
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] en_mask;
    logic [DATA_W-1:0]  din_a;
    logic [DATA_W-1:0]  din_b;
    logic [DATA_W-1:0]  din_c;
    logic [DATA_W-1:0]  din_d;
    logic               out_ready;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [SEL_W-1:0]   sel;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ack;
    logic               busy;

    modport slave (
        input  req, en_mask, din_a, din_b, din_c, din_d, out_ready,
        output out_valid, out_data, sel, grant, ack, busy
    );

    modport master (
        output req, en_mask, din_a, din_b, din_c, din_d, out_ready,
        input  out_valid, out_data, sel, grant, ack, busy
    );

endinterface

// File: rtl/mux_rr_scheduler_mux.sv
// Shared 4:1 byte datapath; purely combinational so the selected byte
// appears on the output in the same cycle as the select.
module mux_rr_scheduler_mux
    import mux_rr_scheduler_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [DATA_W-1:0] din_a_i,
    input  logic [DATA_W-1:0] din_b_i,
    input  logic [DATA_W-1:0] din_c_i,
    input  logic [DATA_W-1:0] din_d_i,
    output logic [DATA_W-1:0] data_o
);

    always_comb begin
        data_o = din_a_i;
        unique case (sel_i)
            2'd0:    data_o = din_a_i;
            2'd1:    data_o = din_b_i;
            2'd2:    data_o = din_c_i;
            2'd3:    data_o = din_d_i;
            default: data_o = din_a_i;
        endcase
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin owner of the shared byte mux: picks a requester, holds it through
// valid/ready backpressure, and rotates after a burst or when the owner goes away.
module mux_rr_scheduler
    import mux_rr_scheduler_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_scheduler_if.slave bus
);

    if (BURST_LEN < 1 || BURST_LEN > MAX_BURST) begin : g_bad_burst_len
        $error("mux_rr_scheduler: BURST_LEN must be within 1..15");
    end

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);

    sched_state_e       state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic [NUM_REQ-1:0] eligible;
    logic               handshake;
    logic               owner_done;
    logic               release_owner;
    logic [SEL_W-1:0]   arb_ptr;
    rr_pick_t           pick;
    logic [DATA_W-1:0]  mux_data;

    // Scan from the highest offset down so the offset closest to start wins.
    function automatic rr_pick_t rr_pick(input logic [NUM_REQ-1:0] elig,
                                         input logic [SEL_W-1:0]   start);
        rr_pick_t         res;
        logic [SEL_W-1:0] idx;
        res.found = 1'b0;
        res.idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = start + SEL_W'(i);
            if (elig[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // On release, arbitration reuses this cycle's eligible set with the advanced pointer.
    always_comb begin
        eligible      = bus.req & bus.en_mask;
        handshake     = (state_q == XFER) && bus.out_ready;
        owner_done    = (burst_cnt_q == BURST_LAST) || !bus.req[sel_q] || !bus.en_mask[sel_q];
        release_owner = handshake && owner_done;
        arb_ptr       = release_owner ? (sel_q + SEL_W'(1)) : ptr_q;
        pick          = rr_pick(eligible, arb_ptr);

        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pick.found) begin
                    state_d     = XFER;
                    sel_d       = pick.idx;
                    grant_d     = sel_to_onehot(pick.idx);
                    burst_cnt_d = '0;
                end
            end
            XFER: begin
                if (handshake) begin
                    if (!release_owner) begin
                        burst_cnt_d = burst_cnt_q + CNT_W'(1);
                    end else begin
                        ptr_d       = arb_ptr;
                        burst_cnt_d = '0;
                        if (pick.found) begin
                            sel_d   = pick.idx;
                            grant_d = sel_to_onehot(pick.idx);
                        end else begin
                            state_d = IDLE;
                            grant_d = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state_q == XFER);
        bus.busy      = (state_q == XFER);
        bus.sel       = sel_q;
        bus.grant     = grant_q;
        bus.ack       = grant_q & {NUM_REQ{(state_q == XFER) && bus.out_ready}};
        bus.out_data  = mux_data;
    end

    mux_rr_scheduler_mux #(
        .DATA_W (DATA_W)
    ) u_mux (
        .sel_i   (sel_q),
        .din_a_i (bus.din_a),
        .din_b_i (bus.din_b),
        .din_c_i (bus.din_c),
        .din_d_i (bus.din_d),
        .data_o  (mux_data)
    );

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: one instance with BURST_LEN=1, one with BURST_LEN=3,
// sharing clock and reset; expected owners and bytes are hand-derived per step.
module tb_mux_rr_scheduler;
    import mux_rr_scheduler_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   ackCount    = 0;

    always #5 clk = ~clk;

    mux_rr_scheduler_if #(.DATA_W(8)) bus1 ();
    mux_rr_scheduler_if #(.DATA_W(8)) bus3 ();

    mux_rr_scheduler #(.DATA_W(8), .BURST_LEN(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    mux_rr_scheduler #(.DATA_W(8), .BURST_LEN(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int target, input logic [3:0] req,
                                 input logic [3:0] enMask, input logic ready);
        if (target == 3) begin
            bus3.req       = req;
            bus3.en_mask   = enMask;
            bus3.out_ready = ready;
        end else begin
            bus1.req       = req;
            bus1.en_mask   = enMask;
            bus1.out_ready = ready;
        end
        #1;
    endtask

    task automatic checkBus1(input string tag, input logic valid, input logic [3:0] grant,
                             input logic [1:0] sel, input logic [7:0] data,
                             input logic [3:0] ack);
        checkOutput({tag, "_valid"}, 32'(bus1.out_valid), 32'(valid));
        checkOutput({tag, "_busy"},  32'(bus1.busy),      32'(valid));
        checkOutput({tag, "_grant"}, 32'(bus1.grant),     32'(grant));
        checkOutput({tag, "_ack"},   32'(bus1.ack),       32'(ack));
        if (valid) begin
            checkOutput({tag, "_sel"},  32'(bus1.sel),      32'(sel));
            checkOutput({tag, "_data"}, 32'(bus1.out_data), 32'(data));
        end
    endtask

    logic [7:0] dinv [4];
    int         exp3 [5];
    int         exp4 [7];

    initial begin
        bus1.req = '0; bus1.en_mask = 4'b1111; bus1.out_ready = 1'b0;
        bus1.din_a = '0; bus1.din_b = '0; bus1.din_c = '0; bus1.din_d = '0;
        bus3.req = '0; bus3.en_mask = 4'b1111; bus3.out_ready = 1'b0;
        bus3.din_a = '0; bus3.din_b = '0; bus3.din_c = '0; bus3.din_d = '0;

        // Reset values, then reset asserted mid-transfer
        step();
        step();
        checkBus1("rst_idle", 1'b0, 4'b0000, 2'd0, 8'h00, 4'b0000);
        checkOutput("rst_sel", 32'(bus1.sel), 32'd0);
        checkOutput("rst_dut3_valid", 32'(bus3.out_valid), 32'd0);
        rst_n = 1'b1;
        bus1.din_c = 8'hC3;
        applyStimulus(1, 4'b0100, 4'b1111, 1'b0);
        checkOutput("rst_pre_valid", 32'(bus1.out_valid), 32'd0);
        step();
        checkBus1("rst_xfer", 1'b1, 4'b0100, 2'd2, 8'hC3, 4'b0000);
        bus1.out_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        checkBus1("rst_mid", 1'b0, 4'b0000, 2'd0, 8'h00, 4'b0000);
        checkOutput("rst_mid_sel", 32'(bus1.sel), 32'd0);
        step();
        applyStimulus(1, 4'b0000, 4'b1111, 1'b0);
        rst_n = 1'b1;
        step();
        checkBus1("rst_after", 1'b0, 4'b0000, 2'd0, 8'h00, 4'b0000);

        // Single requester A
        bus1.din_a = 8'hA5;
        applyStimulus(1, 4'b0001, 4'b1111, 1'b1);
        checkBus1("single_pre", 1'b0, 4'b0000, 2'd0, 8'h00, 4'b0000);
        step();
        checkBus1("single", 1'b1, 4'b0001, 2'd0, 8'hA5, 4'b0001);
        applyStimulus(1, 4'b0000, 4'b1111, 1'b1);
        step();
        checkBus1("single_done", 1'b0, 4'b0000, 2'd0, 8'h00, 4'b0000);

        // All four requesting, pointer now at B
        dinv = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus1.din_a = dinv[0]; bus1.din_b = dinv[1]; bus1.din_c = dinv[2]; bus1.din_d = dinv[3];
        exp3 = '{1, 2, 3, 0, 1};
        applyStimulus(1, 4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            checkBus1($sformatf("rr_%0d", i), 1'b1, 4'(1 << exp3[i]), 2'(exp3[i]),
                      dinv[exp3[i]], 4'(1 << exp3[i]));
        end
        applyStimulus(1, 4'b0000, 4'b1111, 1'b1);
        step();
        checkBus1("rr_done", 1'b0, 4'b0000, 2'd0, 8'h00, 4'b0000);

        // Burst of 3 on the second instance
        bus3.din_a = 8'hA1;
        bus3.din_b = 8'hB2;
        exp4 = '{0, 0, 0, 1, 1, 1, 0};
        applyStimulus(3, 4'b0011, 4'b1111, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
            checkOutput($sformatf("burst_%0d_grant", i), 32'(bus3.grant), 32'(1 << exp4[i]));
            checkOutput($sformatf("burst_%0d_data", i), 32'(bus3.out_data),
                        (exp4[i] == 0) ? 32'hA1 : 32'hB2);
            checkOutput($sformatf("burst_%0d_ack", i), 32'(bus3.ack), 32'(1 << exp4[i]));
            if (i < 6 && bus3.ack != 4'b0000) ackCount++;
        end
        checkOutput("burst_ack_count", 32'(ackCount), 32'd6);
        applyStimulus(3, 4'b0000, 4'b1111, 1'b1);
        step();
        checkOutput("burst_done_valid", 32'(bus3.out_valid), 32'd0);

        // Backpressure while owner D drops its request
        bus1.din_a = 8'h5A;
        bus1.din_d = 8'hD4;
        applyStimulus(1, 4'b1001, 4'b1111, 1'b0);
        step();
        checkBus1("bp_grant", 1'b1, 4'b1000, 2'd3, 8'hD4, 4'b0000);
        applyStimulus(1, 4'b0001, 4'b1111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkBus1($sformatf("bp_hold_%0d", i), 1'b1, 4'b1000, 2'd3, 8'hD4, 4'b0000);
        end
        applyStimulus(1, 4'b0001, 4'b1111, 1'b1);
        checkOutput("bp_ack", 32'(bus1.ack), 32'b1000);
        step();
        checkBus1("bp_rotate", 1'b1, 4'b0001, 2'd0, 8'h5A, 4'b0001);
        applyStimulus(1, 4'b0000, 4'b1111, 1'b1);
        step();
        checkBus1("bp_done", 1'b0, 4'b0000, 2'd0, 8'h00, 4'b0000);

        // Masked requester C never granted until unmasked
        bus1.din_c = 8'hC6;
        applyStimulus(1, 4'b0100, 4'b1011, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            checkBus1($sformatf("mask_%0d", i), 1'b0, 4'b0000, 2'd0, 8'h00, 4'b0000);
        end
        applyStimulus(1, 4'b0100, 4'b1111, 1'b1);
        step();
        checkBus1("unmask", 1'b1, 4'b0100, 2'd2, 8'hC6, 4'b0100);
        applyStimulus(1, 4'b0000, 4'b1111, 1'b1);
        step();
        checkBus1("unmask_done", 1'b0, 4'b0000, 2'd0, 8'h00, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
